chip_quad_gate_tester: RTL and testbench

- Parametrised successor to the fixed single-chip testers: one FSM exercises any 2-input logic gate package (7400/7402/7408/7432/7486/747266 families) selected at run time by gate_mode.
- Drives all NUM_GATES gate inputs with each of the 4 input combinations and waits SETTLE_CYCLES per vector.
- Samples the chip outputs through a synchroniser and reports an overall pass/fail, a per-gate failure mask and the first failing vector.
- Sits between the board pin mux and the result display logic.

---
 rtl/chip_quad_gate_tester_pkg.sv | 49 ++++
 rtl/chip_quad_gate_tester_if.sv | 30 +++
 rtl/chip_quad_gate_tester_sync.sv | 22 ++
 rtl/chip_quad_gate_tester.sv | 137 +++++++++++++
 tb/tb_chip_quad_gate_tester.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/chip_quad_gate_tester_pkg.sv
// Shared types and helpers for the 2-input gate package tester.
// Holds gate modes, FSM state encoding and the reference gate evaluation.
package chip_tester_pkg;

    localparam int NUM_VECTORS = 4;

    typedef enum logic [2:0] {
        GM_NAND = 3'd0,
        GM_NOR  = 3'd1,
        GM_AND  = 3'd2,
        GM_OR   = 3'd3,
        GM_XOR  = 3'd4,
        GM_XNOR = 3'd5
    } gate_mode_t;

    localparam logic [2:0] ST_HALTED = 3'd0;
    localparam logic [2:0] ST_SET    = 3'd1;
    localparam logic [2:0] ST_DRIVE  = 3'd2;
    localparam logic [2:0] ST_SAMPLE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    typedef enum logic [2:0] {
        S_HALTED = ST_HALTED,
        S_SET    = ST_SET,
        S_DRIVE  = ST_DRIVE,
        S_SAMPLE = ST_SAMPLE,
        S_DONE   = ST_DONE
    } state_t;

    function automatic logic mode_legal(input logic [2:0] mode);
        return (mode <= GM_XNOR);
    endfunction

    // Raw 3-bit mode keeps codes 6-7 representable; they evaluate to 0.
    function automatic logic gate_eval(input logic [2:0] mode, input logic a, input logic b);
        logic y;
        case (mode)
            GM_NAND: y = ~(a & b);
            GM_NOR:  y = ~(a | b);
            GM_AND:  y = a & b;
            GM_OR:   y = a | b;
            GM_XOR:  y = a ^ b;
            GM_XNOR: y = ~(a ^ b);
            default: y = 1'b0;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/chip_quad_gate_tester_if.sv
// Pin-mux / display side bundle of the gate package tester.
// master = tester, slave = board and result display.
interface chip_quad_gate_tester_if #(
    parameter int NUM_GATES = 4
);
    logic                 run;
    logic [2:0]           gate_mode;
    logic                 disp_rslt;
    logic [NUM_GATES-1:0] gate_a;
    logic [NUM_GATES-1:0] gate_b;
    logic [NUM_GATES-1:0] gate_y;
    logic                 done;
    logic                 rslt;
    logic [NUM_GATES-1:0] fail_mask;
    logic [1:0]           first_fail_vec;
    logic                 first_fail_valid;
    logic                 mode_err;

    modport master (
        input  run, gate_mode, disp_rslt, gate_y,
        output gate_a, gate_b, done, rslt, fail_mask,
               first_fail_vec, first_fail_valid, mode_err
    );

    modport slave (
        output run, gate_mode, disp_rslt, gate_y,
        input  gate_a, gate_b, done, rslt, fail_mask,
               first_fail_vec, first_fail_valid, mode_err
    );
endinterface

// File: rtl/chip_quad_gate_tester_sync.sv
// Multi-flop synchroniser bringing the asynchronous chip outputs into clk.
module chip_sync #(
    parameter int NUM_GATES   = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_GATES-1:0] gate_y,
    output logic [NUM_GATES-1:0] y_sync
);
    logic [SYNC_STAGES-1:0][NUM_GATES-1:0] stage_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_reg <= '0;
        end else begin
            stage_reg <= {stage_reg[SYNC_STAGES-2:0], gate_y};
        end
    end

    assign y_sync = stage_reg[SYNC_STAGES-1];
endmodule

// File: rtl/chip_quad_gate_tester.sv
// Walks all four {A,B} vectors through a 2-input gate package and
// reports pass/fail, a per-gate failure mask and the first failing vector.
module chip_quad_gate_tester
    import chip_tester_pkg::*;
#(
    parameter int NUM_GATES     = 4,
    parameter int SETTLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    chip_quad_gate_tester_if.master bus
);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [1:0] VEC_LAST    = 2'(NUM_VECTORS - 1);

    state_t               state_reg;
    logic [2:0]           mode_reg;
    logic [1:0]           vec_reg;
    logic [7:0]           settle_reg;
    logic [NUM_GATES-1:0] gate_a_reg;
    logic [NUM_GATES-1:0] gate_b_reg;
    logic [NUM_GATES-1:0] fail_mask_reg;
    logic [1:0]           ffvec_reg;
    logic                 ffv_reg;
    logic                 done_reg;
    logic                 rslt_reg;
    logic                 mode_err_reg;

    logic [NUM_GATES-1:0] y_sync;
    logic [NUM_GATES-1:0] mis;
    logic                 y_exp;
    logic [1:0]           vec_next;

    chip_sync #(
        .NUM_GATES   (NUM_GATES),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .gate_y (bus.gate_y),
        .y_sync (y_sync)
    );

    assign y_exp    = gate_eval(mode_reg, vec_reg[1], vec_reg[0]);
    assign mis      = y_sync ^ {NUM_GATES{y_exp}};
    assign vec_next = vec_reg + 2'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_HALTED;
            mode_reg      <= 3'd0;
            vec_reg       <= 2'd0;
            settle_reg    <= 8'd0;
            gate_a_reg    <= '0;
            gate_b_reg    <= '0;
            fail_mask_reg <= '0;
            ffvec_reg     <= 2'd0;
            ffv_reg       <= 1'b0;
            done_reg      <= 1'b0;
            rslt_reg      <= 1'b0;
            mode_err_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_HALTED: begin
                    if (bus.run) state_reg <= S_SET;
                end
                S_SET: begin
                    mode_reg      <= bus.gate_mode;
                    vec_reg       <= 2'd0;
                    settle_reg    <= 8'd0;
                    fail_mask_reg <= '0;
                    ffvec_reg     <= 2'd0;
                    ffv_reg       <= 1'b0;
                    gate_a_reg    <= '0;
                    gate_b_reg    <= '0;
                    if (mode_legal(bus.gate_mode)) begin
                        rslt_reg     <= 1'b1;
                        mode_err_reg <= 1'b0;
                        state_reg    <= S_DRIVE;
                    end else begin
                        rslt_reg     <= 1'b0;
                        mode_err_reg <= 1'b1;
                        done_reg     <= 1'b1;
                        state_reg    <= S_DONE;
                    end
                end
                S_DRIVE: begin
                    if (settle_reg == SETTLE_LAST) begin
                        settle_reg <= 8'd0;
                        state_reg  <= S_SAMPLE;
                    end else begin
                        settle_reg <= settle_reg + 8'd1;
                    end
                end
                S_SAMPLE: begin
                    fail_mask_reg <= fail_mask_reg | mis;
                    if (|mis) begin
                        rslt_reg <= 1'b0;
                        if (!ffv_reg) begin
                            ffvec_reg <= vec_reg;
                            ffv_reg   <= 1'b1;
                        end
                    end
                    if (vec_reg == VEC_LAST) begin
                        gate_a_reg <= '0;
                        gate_b_reg <= '0;
                        done_reg   <= 1'b1;
                        state_reg  <= S_DONE;
                    end else begin
                        // Next vector goes out on the same edge DRIVE is entered.
                        vec_reg    <= vec_next;
                        gate_a_reg <= {NUM_GATES{vec_next[1]}};
                        gate_b_reg <= {NUM_GATES{vec_next[0]}};
                        state_reg  <= S_DRIVE;
                    end
                end
                S_DONE: begin
                    if (bus.disp_rslt) begin
                        done_reg  <= 1'b0;
                        state_reg <= S_HALTED;
                    end
                end
                default: state_reg <= S_HALTED;
            endcase
        end
    end

    assign bus.gate_a           = gate_a_reg;
    assign bus.gate_b           = gate_b_reg;
    assign bus.done             = done_reg;
    assign bus.rslt             = rslt_reg;
    assign bus.fail_mask        = fail_mask_reg;
    assign bus.first_fail_vec   = ffvec_reg;
    assign bus.first_fail_valid = ffv_reg;
    assign bus.mode_err         = mode_err_reg;
endmodule

// File: tb/tb_chip_quad_gate_tester.sv
// Directed bench for chip_quad_gate_tester: truth-table chip model with stuck
// faults, truth-table result model, and a per-cycle result comparator.
module tb_chip_quad_gate_tester;
    import chip_tester_pkg::*;

    localparam int NG = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    chip_quad_gate_tester_if #(.NUM_GATES(NG)) bus ();
    chip_quad_gate_tester_if #(.NUM_GATES(NG)) bus3 ();

    chip_quad_gate_tester #(.NUM_GATES(NG), .SETTLE_CYCLES(4), .SYNC_STAGES(2)) dut (
        .clk (clk), .rst (rst), .bus (bus)
    );
    chip_quad_gate_tester #(.NUM_GATES(NG), .SETTLE_CYCLES(3), .SYNC_STAGES(2)) dut3 (
        .clk (clk), .rst (rst), .bus (bus3)
    );

    // Truth table per mode, bit index = {a,b}.
    function automatic logic [3:0] truth(input logic [2:0] m);
        case (m)
            3'd0:    return 4'b0111;
            3'd1:    return 4'b0001;
            3'd2:    return 4'b1000;
            3'd3:    return 4'b1110;
            3'd4:    return 4'b0110;
            3'd5:    return 4'b1001;
            default: return 4'b0000;
        endcase
    endfunction

    logic [2:0]    chip_kind = 3'd0;
    logic [NG-1:0] stuck_en  = '0;
    logic [NG-1:0] stuck_val = '0;
    logic [NG-1:0] y_chip;
    logic [3:0]    tt_chip;

    always_comb begin
        tt_chip = truth(chip_kind);
        y_chip  = '0;
        for (int i = 0; i < NG; i++)
            y_chip[i] = stuck_en[i] ? stuck_val[i] : tt_chip[{bus.gate_a[i], bus.gate_b[i]}];
    end
    assign bus.gate_y  = y_chip;
    assign bus3.gate_y = bus3.gate_a ^ bus3.gate_b;

    logic          exp_rslt, exp_ffv, exp_err;
    logic [NG-1:0] exp_mask;
    logic [1:0]    exp_ffvec;
    int            exp_lat;
    logic          res_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic build_expect(input logic [2:0] mode, input logic [2:0] kind,
                                input logic [NG-1:0] s_en, input logic [NG-1:0] s_val,
                                input int settle);
        logic [3:0]    tt_ref, tt_k;
        logic [NG-1:0] m;
        logic          got;
        exp_err   = (mode > 3'd5);
        exp_rslt  = !exp_err;
        exp_mask  = '0;
        exp_ffv   = 1'b0;
        exp_ffvec = 2'b00;
        exp_lat   = exp_err ? 1 : 1 + 4 * (settle + 1);
        tt_ref    = truth(mode);
        tt_k      = truth(kind);
        if (!exp_err) begin
            for (int v = 0; v < 4; v++) begin
                m = '0;
                for (int g = 0; g < NG; g++) begin
                    got = s_en[g] ? s_val[g] : tt_k[v];
                    if (got != tt_ref[v]) m[g] = 1'b1;
                end
                exp_mask = exp_mask | m;
                if (m != '0) begin
                    exp_rslt = 1'b0;
                    if (!exp_ffv) begin
                        exp_ffv   = 1'b1;
                        exp_ffvec = 2'(v);
                    end
                end
            end
        end
    endtask

    // Result comparator: every cycle results are meaningful (DONE and the HALTED hold after it).
    always @(negedge clk) begin
        if (res_valid) begin
            chk("rslt", 32'(bus.rslt), 32'(exp_rslt));
            chk("fail_mask", 32'(bus.fail_mask), 32'(exp_mask));
            chk("first_fail_valid", 32'(bus.first_fail_valid), 32'(exp_ffv));
            chk("first_fail_vec", 32'(bus.first_fail_vec), 32'(exp_ffvec));
            chk("mode_err", 32'(bus.mode_err), 32'(exp_err));
            chk("gates_idle", 32'({bus.gate_a, bus.gate_b}), 32'd0);
        end
    end

    task automatic run_case(input string name, input logic [2:0] mode, input logic [2:0] kind,
                            input logic [NG-1:0] s_en, input logic [NG-1:0] s_val,
                            input logic lit_rslt, input logic [NG-1:0] lit_mask,
                            input logic lit_ffv, input logic [1:0] lit_ffvec,
                            input logic lit_err, input int lit_lat);
        int lat;
        logic toggled;
        res_valid = 1'b0;
        chip_kind = kind;
        stuck_en  = s_en;
        stuck_val = s_val;
        build_expect(mode, kind, s_en, s_val, 4);
        chk({name, "_model_rslt"}, 32'(exp_rslt), 32'(lit_rslt));
        chk({name, "_model_mask"}, 32'(exp_mask), 32'(lit_mask));
        chk({name, "_model_ffv"}, 32'(exp_ffv), 32'(lit_ffv));
        chk({name, "_model_ffvec"}, 32'(exp_ffvec), 32'(lit_ffvec));
        chk({name, "_model_err"}, 32'(exp_err), 32'(lit_err));
        chk({name, "_model_lat"}, 32'(exp_lat), 32'(lit_lat));
        @(negedge clk);
        bus.gate_mode = mode;
        bus.run       = 1'b1;
        @(posedge clk);
        #1 bus.run = 1'b0;
        lat     = 0;
        toggled = 1'b0;
        while (!bus.done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            toggled = toggled | (|bus.gate_a) | (|bus.gate_b);
        end
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({name, "_gates_toggled"}, 32'(toggled), 32'(!exp_err));
        res_valid = 1'b1;
        repeat (2) @(negedge clk);
        bus.run = 1'b1;
        @(posedge clk);
        #1 bus.run = 1'b0;
        chk({name, "_run_ignored_in_done"}, 32'(bus.done), 32'd1);
        @(negedge clk);
        bus.disp_rslt = 1'b1;
        @(posedge clk);
        #1 bus.disp_rslt = 1'b0;
        chk({name, "_done_after_ack"}, 32'(bus.done), 32'd0);
        repeat (3) @(negedge clk);
        chk({name, "_halted_stays"}, 32'(bus.done), 32'd0);
        $display("case %s: lat=%0d rslt=%0b mask=%b ffv=%0b ffvec=%b err=%0b", name, lat,
                 bus.rslt, bus.fail_mask, bus.first_fail_valid, bus.first_fail_vec, bus.mode_err);
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, 32'({bus.gate_a, bus.gate_b, bus.done, bus.rslt, bus.fail_mask,
                       bus.first_fail_valid, bus.first_fail_vec, bus.mode_err}), 32'd0);
    endtask

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int lat;
        bus.run = 1'b0;  bus.gate_mode = 3'd0;  bus.disp_rslt = 1'b0;
        bus3.run = 1'b0; bus3.gate_mode = 3'd4; bus3.disp_rslt = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk_all_zero("reset_state");
        @(negedge clk);
        rst = 1'b0;

        run_case("nand_ok",     3'd0, 3'd0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'b00, 1'b0, 21);
        run_case("nand_stuck2", 3'd0, 3'd0, 4'b0100, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'b11, 1'b0, 21);
        run_case("nor_vs_nand", 3'd1, 3'd0, 4'b0000, 4'b0000, 1'b0, 4'b1111, 1'b1, 2'b01, 1'b0, 21);
        run_case("illegal7",    3'd7, 3'd0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'b00, 1'b1, 1);
        run_case("and_stuck0",  3'd2, 3'd2, 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1, 2'b11, 1'b0, 21);
        run_case("or_stuck3",   3'd3, 3'd3, 4'b1000, 4'b1000, 1'b0, 4'b1000, 1'b1, 2'b00, 1'b0, 21);
        run_case("xnor_ok",     3'd5, 3'd5, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'b00, 1'b0, 21);

        // Abort while vector 10 is being driven.
        res_valid = 1'b0;
        chip_kind = 3'd0; stuck_en = '0; stuck_val = '0;
        @(negedge clk);
        bus.gate_mode = 3'd0;
        bus.run       = 1'b1;
        @(posedge clk);
        #1 bus.run = 1'b0;
        repeat (11) @(posedge clk);
        #2;
        chk("pre_reset_gate_a", 32'(bus.gate_a), 32'hF);
        chk("pre_reset_gate_b", 32'(bus.gate_b), 32'h0);
        rst = 1'b1;
        #1 chk_all_zero("mid_test_reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("after_reset_halted");
        $display("case mid_reset: outputs=%b", {bus.gate_a, bus.gate_b, bus.done, bus.rslt});
        run_case("after_reset", 3'd0, 3'd0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'b00, 1'b0, 21);

        // SETTLE_CYCLES=3 instance, Run held through HALTED.
        res_valid = 1'b0;
        build_expect(3'd4, 3'd4, 4'b0000, 4'b0000, 3);
        chk("s3_model_lat", 32'(exp_lat), 32'd17);
        @(negedge clk);
        bus3.run = 1'b1;
        @(posedge clk);
        #1 lat = 0;
        while (!bus3.done && lat < 200) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("s3_first_latency", 32'(lat), 32'(exp_lat));
        chk("s3_first_rslt", 32'(bus3.rslt), 32'(exp_rslt));
        @(negedge clk);
        bus3.disp_rslt = 1'b1;
        @(posedge clk);
        #1 bus3.disp_rslt = 1'b0;
        chk("s3_done_after_ack", 32'(bus3.done), 32'd0);
        chk("s3_rslt_retained", 32'(bus3.rslt), 32'(exp_rslt));
        chk("s3_mask_retained", 32'(bus3.fail_mask), 32'(exp_mask));
        @(posedge clk);
        #1 lat = 0;
        while (!bus3.done && lat < 200) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("s3_second_latency", 32'(lat), 32'(exp_lat));
        chk("s3_second_rslt", 32'(bus3.rslt), 32'(exp_rslt));
        $display("case s3_rerun: lat=%0d rslt=%0b mask=%b", lat, bus3.rslt, bus3.fail_mask);
        bus3.run = 1'b0;
        @(negedge clk);
        bus3.disp_rslt = 1'b1;
        @(negedge clk);
        bus3.disp_rslt = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
